// File: rtl/traffic_pkg.sv
// traffic_pkg: light encodings, boolean constants and debounce state shared with the light controller
package traffic_pkg;
    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    typedef enum logic {IDLE, PRESENT} deb_state_t;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchroniser plus run-length debounce FSM emitting a one-cycle arrive pulse
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic sensor_raw,
    output logic arrive
);
    localparam int RW = $clog2(DEBOUNCE_CYC);
    localparam logic [RW-1:0] RUN_LAST = RW'(DEBOUNCE_CYC - 1);
    logic s1, s, opp, done;
    logic [RW-1:0] run;
    deb_state_t state, state_nx;
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            s1 <= FALSE;
            s  <= FALSE;
        end else begin
            s1 <= sensor_raw;
            s  <= s1;
        end
    end
    always_comb begin
        opp  = (state == IDLE) ? s : !s;
        done = opp && (run == RUN_LAST);
    end
    always_ff @(posedge clk or posedge clear) begin
        if (clear) run <= '0;
        else       run <= (opp && !done) ? run + 1'b1 : '0;
    end
    always_ff @(posedge clk or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (done) state_nx = (state == IDLE) ? PRESENT : IDLE;
    end
    always_comb begin
        arrive = done && (state == IDLE);
    end
endmodule

// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner: debounced car queue with green-light discharge and starvation-aware request x
module car_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 4,
    parameter int THRESH       = 2,
    parameter int MAX_WAIT     = 32,
    parameter int DEPART_CYC   = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sensor_raw,
    input  logic [1:0]       EW,
    output logic             x,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow
);
    localparam int DW = $clog2(DEPART_CYC + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [DW-1:0]    DT_LAST = DW'(DEPART_CYC - 1);
    localparam logic [WW-1:0]    WT_MAX  = WW'(MAX_WAIT);
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic arrive, depart, green, busy;
    logic [DW-1:0] dt;
    logic [WW-1:0] wt;
    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
        .clk        (clk),
        .clear      (clear),
        .sensor_raw (sensor_raw),
        .arrive     (arrive)
    );
    always_comb begin
        green  = (EW == GREEN);
        busy   = (car_count != '0);
        depart = green && busy && (dt == DT_LAST);
    end
    always_ff @(posedge clk or posedge clear) begin
        if (clear) dt <= '0;
        else       dt <= (green && busy && !depart) ? dt + 1'b1 : '0;
    end
    always_ff @(posedge clk or posedge clear) begin
        if (clear)              wt <= '0;
        else if (green || !busy) wt <= '0;
        else if (wt != WT_MAX)  wt <= wt + 1'b1;
    end
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            car_count <= '0;
            overflow  <= FALSE;
            x         <= FALSE;
        end else begin
            if (arrive && !depart) begin
                if (car_count == CNT_MAX) overflow <= TRUE;
                else car_count <= car_count + 1'b1;
            end else if (depart && !arrive) begin
                car_count <= car_count - 1'b1;
            end
            x <= (car_count >= THR) || (busy && (wt == WT_MAX));
        end
    end
endmodule
